// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, widths, fetch state encoding
// and the fetch queue entry layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch unit bus: instruction memory handshake, decoder
// delivery and redirect inputs.
interface instruction_fetch_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            available;
  logic            decode_pulse;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    output decode_pulse,
    output instr,
    output instr_pc,
    input  imem_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  available,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  decode_pulse,
    input  instr,
    input  instr_pc,
    output imem_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output available,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer of {pc, instr} entries
// with push/pop/flush and occupancy count.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC, single-outstanding memory FSM,
// instruction queue and one-cycle decode pulse generator.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 4
) (
  input logic                 clock,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  localparam int AW = $clog2(QDEPTH);

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] req_pc;
  logic            pulse;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            accept;
  logic            push;
  logic            issue;
  logic            redirect;
  fetch_entry_t    head;
  fetch_entry_t    entry;
  logic [AW:0]     count;
  logic            empty;
  logic            full;

  assign redirect = bus.redirect_valid;

  // Only one request is ever in flight, so a free slot now
  // is the slot its response will land in.
  assign bus.imem_req  = (state == ST_FETCH) && !full && !reset;
  assign bus.imem_addr = pc;
  assign accept        = bus.imem_req && bus.imem_ready;

  assign issue = !empty && bus.available && !pulse && !redirect;

  assign entry.pc    = req_pc;
  assign entry.instr = bus.imem_resp_data;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (accept) begin
          state_nx = redirect ? ST_DROP : ST_WAIT;
          pc_nx    = pc + 32'd4;
        end
      end
      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          state_nx = ST_FETCH;
          push     = !redirect;
        end else if (redirect) begin
          state_nx = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.imem_resp_valid) state_nx = ST_FETCH;
      end
      default: state_nx = ST_FETCH;
    endcase
    if (redirect) pc_nx = align_pc(bus.redirect_pc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      req_pc     <= '0;
      pulse      <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      pulse <= issue;
      if (accept) req_pc <= pc;
      if (issue) begin
        instr_q    <= head.instr;
        instr_pc_q <= head.pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .flush (redirect),
    .wdata (entry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign bus.decode_pulse = pulse;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with a
// behavioural memory and program-order reference model.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sbq[$];
  logic [31:0] fetch_pc;
  bit          outstanding;
  bit          stale;
  logic [31:0] out_addr;
  int          lat;
  int          max_lat = 3;
  logic [31:0] last_addr;
  bit          last_pending;
  bit          exp_issue;
  int          accepts;
  int          pulses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    fetch_pc     = RESET_PC;
    outstanding  = 1'b0;
    stale        = 1'b0;
    last_pending = 1'b0;
    exp_issue    = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.imem_ready      = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.available       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
  endtask

  task automatic step(input int p_ready,
                      input int p_redir,
                      input int p_avail);
    bit          rdy;
    bit          rdr;
    bit          av;
    bit          rv;
    bit          acc;
    logic [31:0] rpc;
    exp_t        e;
    @(negedge clock);
    rdy = int'($urandom_range(0, 99)) < p_ready;
    rdr = int'($urandom_range(0, 99)) < p_redir;
    av  = int'($urandom_range(0, 99)) < p_avail;
    rpc = 32'($urandom_range(0, 1023));
    rv  = 1'b0;
    if (outstanding) begin
      if (lat == 0) rv = 1'b1;
      else lat--;
    end
    chk("req_rule", 32'(bus.imem_req),
        32'(!outstanding && sbq.size() < QDEPTH));
    if (bus.imem_req) begin
      chk("addr_model", bus.imem_addr, fetch_pc);
      if (last_pending) chk("addr_stable", bus.imem_addr, last_addr);
    end
    exp_issue = (sbq.size() > 0) && av && !bus.decode_pulse && !rdr;
    acc = bus.imem_req && rdy;
    bus.imem_ready      = rdy;
    bus.redirect_valid  = rdr;
    bus.redirect_pc     = rpc;
    bus.available       = av;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? mem_word(out_addr) : $urandom;
    if (rv) begin
      if (!stale && !rdr) begin
        e.pc   = out_addr;
        e.data = mem_word(out_addr);
        sbq.push_back(e);
      end
      outstanding = 1'b0;
    end
    if (rdr) begin
      sbq.delete();
      stale = stale | outstanding;
    end
    if (acc) begin
      outstanding = 1'b1;
      stale       = rdr;
      out_addr    = bus.imem_addr;
      lat         = $urandom_range(0, max_lat);
      accepts++;
    end
    if (rdr) fetch_pc = {rpc[31:2], 2'b00};
    else if (acc) fetch_pc = fetch_pc + 32'd4;
    last_pending = bus.imem_req && !rdy && !rdr;
    last_addr    = bus.imem_addr;
  endtask

  bit          prev_pulse;
  logic [31:0] last_instr;
  logic [31:0] last_ipc;
  exp_t        mon_e;

  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      prev_pulse = 1'b0;
      last_instr = '0;
      last_ipc   = '0;
    end else begin
      chk("pulse_when", 32'(bus.decode_pulse), 32'(exp_issue));
      if (bus.decode_pulse) begin
        pulses++;
        chk("pulse_gap", 32'(prev_pulse), 32'd0);
        chk("pulse_avail", 32'(bus.available), 32'd1);
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pulse_unexpected: got pc %h, expected no issue",
                   bus.instr_pc);
        end else begin
          mon_e = sbq.pop_front();
          chk("instr_pc", bus.instr_pc, mon_e.pc);
          chk("instr", bus.instr, mon_e.data);
        end
        last_instr = bus.instr;
        last_ipc   = bus.instr_pc;
      end else begin
        chk("instr_hold", bus.instr, last_instr);
        chk("instr_pc_hold", bus.instr_pc, last_ipc);
      end
      prev_pulse = bus.decode_pulse;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_pulse"}, 32'(bus.decode_pulse), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, RESET_PC);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    max_lat = 0;
    accepts = 0;
    pulses  = 0;
    repeat (20) step(100, 0, 0);
    chk("fill_accepts", accepts, QDEPTH);
    chk("fill_no_pulse", pulses, 0);

    pulses = 0;
    repeat (10) step(0, 0, 100);
    chk("drain_pulses", pulses, 4);
    chk("drain_empty", sbq.size(), 0);

    max_lat = 3;
    repeat (3000) step(70, 4, 80);

    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step(60, 0, 0);
      found = outstanding && sbq.size() >= 2;
    end
    chk("reset_setup", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    clear_inputs();
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    accepts = 0;
    repeat (300) step(70, 4, 80);
    chk("post_reset_fetching", 32'(accepts > 0), 32'd1);

    repeat (20) step(0, 0, 100);
    chk("final_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
